// File: rtl/esm_issue_window_if.sv
// Fetch/execute/writeback signal bundle for esm_issue_window.
// master drives instructions, execute ready and writebacks; slave is the window.
interface esm_issue_window_if #(
    parameter int unsigned IW     = 32,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned REGNUM = 32
);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned RW = $clog2(REGNUM);

    logic          in_valid;
    logic          in_ready;
    logic [IW-1:0] in_instr;
    logic          in_regwrite;
    logic          in_alusrc;
    logic          out_valid;
    logic          out_ready;
    logic [IW-1:0] out_instr;
    logic          wb_valid;
    logic [RW-1:0] wb_rd;
    logic [CW-1:0] count;

    modport master (
        output in_valid, in_instr, in_regwrite, in_alusrc, out_ready, wb_valid, wb_rd,
        input  in_ready, out_valid, out_instr, count
    );

    modport slave (
        input  in_valid, in_instr, in_regwrite, in_alusrc, out_ready, wb_valid, wb_rd,
        output in_ready, out_valid, out_instr, count
    );
endinterface

// File: rtl/esm_issue_window.sv
// Age-ordered issue window with register scoreboard; issues the oldest hazard-free
// entry (MODE=1) or strictly the head entry (MODE=0). Collapsing queue, entry 0 oldest.
module esm_issue_window #(
    parameter int unsigned IW     = 32,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned REGNUM = 32,
    parameter int unsigned MODE   = 1
) (
    input logic               clk,
    input logic               rst,
    esm_issue_window_if.slave bus
);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned KW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [IW-1:0]     instr_q [DEPTH];
    logic [DEPTH-1:0]  regwrite_q;
    logic [DEPTH-1:0]  alusrc_q;
    logic [CW-1:0]     count_q;
    logic [REGNUM-1:0] busy_q;
    logic [REGNUM-1:0] busy_nxt;

    logic [4:0]        rd  [DEPTH];
    logic [4:0]        rs1 [DEPTH];
    logic [4:0]        rs2 [DEPTH];
    logic [DEPTH-1:0]  live;
    logic [DEPTH-1:0]  wr;
    logic [DEPTH-1:0]  use1;
    logic [DEPTH-1:0]  use2;
    logic [DEPTH-1:0]  eligible;
    logic [KW-1:0]     sel;
    logic              sel_valid;
    logic              in_ready_int;
    logic              accept;
    logic              issue;
    logic [CW-1:0]     tail;

    // Field decode; x0 never counts as a read or write
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            rd[i]   = instr_q[i][11:7];
            rs1[i]  = instr_q[i][19:15];
            rs2[i]  = instr_q[i][24:20];
            live[i] = (CW'(i) < count_q);
            wr[i]   = regwrite_q[i] & (rd[i] != 5'd0);
            use1[i] = (rs1[i] != 5'd0);
            use2[i] = ~alusrc_q[i] & (rs2[i] != 5'd0);
        end
    end

    // Eligibility: scoreboard clear, plus no RAW/WAW/WAR against any older entry
    always_comb begin
        eligible = '0;
        for (int i = 0; i < DEPTH; i++) begin
            logic ok;
            ok = live[i];
            if (use1[i] && busy_q[rs1[i]]) ok = 1'b0;
            if (use2[i] && busy_q[rs2[i]]) ok = 1'b0;
            if (wr[i] && busy_q[rd[i]])    ok = 1'b0;
            if (MODE == 0) begin
                if (i != 0) ok = 1'b0;
            end else begin
                for (int j = 0; j < DEPTH; j++) begin
                    if (j < i) begin
                        if (wr[j] && ((use1[i] && rs1[i] == rd[j]) ||
                                      (use2[i] && rs2[i] == rd[j]) ||
                                      (wr[i]   && rd[i]  == rd[j])))
                            ok = 1'b0;
                        if (wr[i] && ((use1[j] && rs1[j] == rd[i]) ||
                                      (use2[j] && rs2[j] == rd[i])))
                            ok = 1'b0;
                    end
                end
            end
            eligible[i] = ok;
        end
    end

    // Lowest eligible index wins
    always_comb begin
        sel = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (eligible[i]) sel = KW'(i);
        end
        sel_valid = |eligible;
    end

    assign in_ready_int  = (count_q < CW'(DEPTH));
    assign accept        = bus.in_valid & in_ready_int;
    assign issue         = sel_valid & bus.out_ready;
    assign tail          = issue ? (count_q - CW'(1)) : count_q;

    assign bus.in_ready  = in_ready_int;
    assign bus.out_valid = sel_valid;
    assign bus.out_instr = sel_valid ? instr_q[sel] : '0;
    assign bus.count     = count_q;

    // Scoreboard: issuing a writer sets busy after any same-cycle writeback clear
    always_comb begin
        busy_nxt = busy_q;
        if (bus.wb_valid) busy_nxt[bus.wb_rd] = 1'b0;
        if (issue && wr[sel]) busy_nxt[rd[sel]] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) instr_q[i] <= '0;
            regwrite_q <= '0;
            alusrc_q   <= '0;
            count_q    <= '0;
            busy_q     <= '0;
        end else begin
            busy_q <= busy_nxt;
            if (issue) begin
                for (int i = 0; i < DEPTH - 1; i++) begin
                    if (KW'(i) >= sel) begin
                        instr_q[i]    <= instr_q[i+1];
                        regwrite_q[i] <= regwrite_q[i+1];
                        alusrc_q[i]   <= alusrc_q[i+1];
                    end
                end
            end
            // Accept lands at the post-shift tail, overriding any shift into that slot
            if (accept) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (CW'(i) == tail) begin
                        instr_q[i]    <= bus.in_instr;
                        regwrite_q[i] <= bus.in_regwrite;
                        alusrc_q[i]   <= bus.in_alusrc;
                    end
                end
            end
            if (accept && !issue)      count_q <= count_q + CW'(1);
            else if (issue && !accept) count_q <= count_q - CW'(1);
        end
    end
endmodule

// File: tb/tb_esm_issue_window.sv
// Bench for esm_issue_window: directed scenarios plus randomized traffic checked
// against a queue/set-based reference of the issue rules.
module tb_esm_issue_window;
    localparam int unsigned DEPTH = 16;

    logic clk;
    logic rst;
    int   total;
    int   passed;

    esm_issue_window_if #(.IW(32), .DEPTH(DEPTH), .REGNUM(32)) bi ();
    esm_issue_window_if #(.IW(32), .DEPTH(DEPTH), .REGNUM(32)) bo ();

    esm_issue_window #(.IW(32), .DEPTH(DEPTH), .REGNUM(32), .MODE(1)) u_ooo (
        .clk(clk), .rst(rst), .bus(bi)
    );
    esm_issue_window #(.IW(32), .DEPTH(DEPTH), .REGNUM(32), .MODE(0)) u_ino (
        .clk(clk), .rst(rst), .bus(bo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        bit          rw;
        bit          as;
    } ent_t;

    ent_t        mq[$];
    bit          mbusy[32];
    logic [31:0] dut_iss[$];
    logic [31:0] dut_iss0[$];

    function automatic logic [31:0] mk(input int rd, input int rs1, input int rs2);
        return {7'd0, 5'(rs2), 5'(rs1), 3'd0, 5'(rd), 7'b0110011};
    endfunction

    // Reference pick: walk oldest to youngest, accumulating the regs older entries read/write
    function automatic int m_pick();
        bit ow[32];
        bit orr[32];
        int rdv, r1, r2;
        bit w, u1, u2, ok;
        ow  = '{default: 1'b0};
        orr = '{default: 1'b0};
        for (int i = 0; i < mq.size(); i++) begin
            rdv = int'(mq[i].instr[11:7]);
            r1  = int'(mq[i].instr[19:15]);
            r2  = int'(mq[i].instr[24:20]);
            w   = mq[i].rw && (rdv != 0);
            u1  = (r1 != 0);
            u2  = !mq[i].as && (r2 != 0);
            ok  = 1'b1;
            if (u1 && (mbusy[r1] || ow[r1]))               ok = 1'b0;
            if (u2 && (mbusy[r2] || ow[r2]))               ok = 1'b0;
            if (w && (mbusy[rdv] || ow[rdv] || orr[rdv])) ok = 1'b0;
            if (ok) return i;
            if (w)  ow[rdv] = 1'b1;
            if (u1) orr[r1] = 1'b1;
            if (u2) orr[r2] = 1'b1;
        end
        return -1;
    endfunction

    // One clock: advance the reference with the inputs presented this cycle
    task automatic tick();
        int   k, wbr, rdv;
        bit   acc, iss, wbv;
        ent_t e;
        k       = m_pick();
        acc     = bi.in_valid && (mq.size() < DEPTH);
        iss     = (k >= 0) && bi.out_ready;
        wbv     = bi.wb_valid;
        wbr     = int'(bi.wb_rd);
        e.instr = bi.in_instr;
        e.rw    = bi.in_regwrite;
        e.as    = bi.in_alusrc;
        if (bi.out_valid && bi.out_ready) dut_iss.push_back(bi.out_instr);
        if (bo.out_valid && bo.out_ready) dut_iss0.push_back(bo.out_instr);
        @(posedge clk);
        #1;
        if (rst) begin
            mq.delete();
            mbusy = '{default: 1'b0};
        end else begin
            if (wbv) mbusy[wbr] = 1'b0;
            if (iss) begin
                rdv = int'(mq[k].instr[11:7]);
                if (mq[k].rw && rdv != 0) mbusy[rdv] = 1'b1;
                mq.delete(k);
            end
            if (acc) mq.push_back(e);
        end
    endtask

    task automatic drv(input logic [31:0] ins);
        bi.in_valid = 1'b1; bi.in_instr = ins; bi.in_regwrite = 1'b1; bi.in_alusrc = 1'b0;
    endtask

    task automatic drv0(input logic [31:0] ins);
        bo.in_valid = 1'b1; bo.in_instr = ins; bo.in_regwrite = 1'b1; bo.in_alusrc = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bi.in_valid = 1'b0; bi.in_instr = '0; bi.in_regwrite = 1'b0; bi.in_alusrc = 1'b0;
        bi.out_ready = 1'b0; bi.wb_valid = 1'b0; bi.wb_rd = '0;
        bo.in_valid = 1'b0; bo.in_instr = '0; bo.in_regwrite = 1'b0; bo.in_alusrc = 1'b0;
        bo.out_ready = 1'b0; bo.wb_valid = 1'b0; bo.wb_rd = '0;
        tick();
        tick();
        rst = 1'b0;
        dut_iss.delete();
        dut_iss0.delete();
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if (bi.count !== 5'd0 || bi.out_valid !== 1'b0 || bi.in_ready !== 1'b1 || bi.out_instr !== 32'd0)
            $display("FAIL reset_idle: count=%0d valid=%0b ready=%0b instr=%h want 0/0/1/0",
                     bi.count, bi.out_valid, bi.in_ready, bi.out_instr);
        else passed++;
        bi.out_ready = 1'b1;
        drv(mk(5, 0, 0)); tick();
        bi.in_valid = 1'b0; tick();
        bi.out_ready = 1'b0;
        drv(mk(6, 5, 0)); tick();
        drv(mk(7, 5, 0)); tick();
        bi.in_valid = 1'b0;
        total++;
        if (bi.count !== 5'd2) $display("FAIL reset_prefill: count=%0d want 2", bi.count);
        else passed++;
        rst = 1'b1; tick(); rst = 1'b0;
        total++;
        if (bi.count !== 5'd0 || bi.out_valid !== 1'b0 || bi.in_ready !== 1'b1)
            $display("FAIL reset_mid: count=%0d valid=%0b ready=%0b want 0/0/1",
                     bi.count, bi.out_valid, bi.in_ready);
        else passed++;
        drv(mk(8, 5, 5)); tick(); bi.in_valid = 1'b0;
        total++;
        if (bi.out_valid !== 1'b1 || bi.out_instr !== mk(8, 5, 5))
            $display("FAIL reset_busy_clear: valid=%0b instr=%h want 1/%h",
                     bi.out_valid, bi.out_instr, mk(8, 5, 5));
        else passed++;
    endtask

    task automatic test_out_of_order();
        logic [31:0] a, b, c;
        a = mk(5, 1, 2); b = mk(6, 5, 3); c = mk(7, 8, 9);
        do_reset();
        bi.out_ready = 1'b1;
        drv(a); tick();
        total++;
        if (bi.out_valid !== 1'b1 || bi.out_instr !== a)
            $display("FAIL ooo_A_latency: valid=%0b instr=%h want 1/%h", bi.out_valid, bi.out_instr, a);
        else passed++;
        drv(b); tick();
        total++;
        if (bi.out_valid !== 1'b0) $display("FAIL ooo_B_blocked: valid=%0b want 0", bi.out_valid);
        else passed++;
        drv(c); tick();
        total++;
        if (bi.out_valid !== 1'b1 || bi.out_instr !== c)
            $display("FAIL ooo_C_bypass: valid=%0b instr=%h want 1/%h", bi.out_valid, bi.out_instr, c);
        else passed++;
        bi.in_valid = 1'b0; tick();
        total++;
        if (bi.out_valid !== 1'b0 || bi.count !== 5'd1)
            $display("FAIL ooo_B_held: valid=%0b count=%0d want 0/1", bi.out_valid, bi.count);
        else passed++;
        bi.wb_valid = 1'b1; bi.wb_rd = 5'd5; tick(); bi.wb_valid = 1'b0;
        total++;
        if (bi.out_valid !== 1'b1 || bi.out_instr !== b)
            $display("FAIL ooo_B_after_wb: valid=%0b instr=%h want 1/%h", bi.out_valid, bi.out_instr, b);
        else passed++;
        tick();
        total++;
        if (dut_iss.size() != 3 || dut_iss[0] !== a || dut_iss[1] !== c || dut_iss[2] !== b || bi.count !== 5'd0)
            $display("FAIL ooo_order: issued=%0d count=%0d want A,C,B and 0", dut_iss.size(), bi.count);
        else passed++;
    endtask

    task automatic test_in_order();
        logic [31:0] a, b, c;
        a = mk(5, 1, 2); b = mk(6, 5, 3); c = mk(7, 8, 9);
        do_reset();
        bo.out_ready = 1'b1;
        drv0(a); tick();
        drv0(b); tick();
        drv0(c); tick();
        bo.in_valid = 1'b0;
        total++;
        if (bo.out_valid !== 1'b0 || bo.count !== 5'd2)
            $display("FAIL ino_C_not_bypass: valid=%0b count=%0d want 0/2", bo.out_valid, bo.count);
        else passed++;
        tick();
        total++;
        if (bo.out_valid !== 1'b0) $display("FAIL ino_head_blocked: valid=%0b want 0", bo.out_valid);
        else passed++;
        bo.wb_valid = 1'b1; bo.wb_rd = 5'd5; tick(); bo.wb_valid = 1'b0;
        total++;
        if (bo.out_valid !== 1'b1 || bo.out_instr !== b)
            $display("FAIL ino_B_after_wb: valid=%0b instr=%h want 1/%h", bo.out_valid, bo.out_instr, b);
        else passed++;
        tick(); tick();
        total++;
        if (dut_iss0.size() != 3 || dut_iss0[0] !== a || dut_iss0[1] !== b || dut_iss0[2] !== c)
            $display("FAIL ino_order: issued=%0d want A,B,C", dut_iss0.size());
        else passed++;
    endtask

    task automatic test_war_waw();
        logic [31:0] p, a, d, e, f;
        p = mk(5, 0, 0); a = mk(10, 1, 5); d = mk(1, 2, 3); e = mk(10, 2, 3); f = mk(12, 2, 3);
        do_reset();
        bi.out_ready = 1'b1;
        drv(p); tick();
        drv(a); tick();
        drv(d); tick();
        drv(e); tick();
        total++;
        if (bi.out_valid !== 1'b0 || bi.count !== 5'd3)
            $display("FAIL hz_D_E_blocked: valid=%0b count=%0d want 0/3", bi.out_valid, bi.count);
        else passed++;
        drv(f); tick();
        total++;
        if (bi.out_valid !== 1'b1 || bi.out_instr !== f)
            $display("FAIL hz_F_indep: valid=%0b instr=%h want 1/%h", bi.out_valid, bi.out_instr, f);
        else passed++;
        bi.in_valid = 1'b0; tick();
        bi.wb_valid = 1'b1; bi.wb_rd = 5'd5; tick(); bi.wb_valid = 1'b0;
        total++;
        if (bi.out_valid !== 1'b1 || bi.out_instr !== a)
            $display("FAIL hz_A_first: valid=%0b instr=%h want 1/%h", bi.out_valid, bi.out_instr, a);
        else passed++;
        tick();
        tick();
        total++;
        if (bi.out_valid !== 1'b0 || bi.count !== 5'd1)
            $display("FAIL hz_E_waw_busy: valid=%0b count=%0d want 0/1", bi.out_valid, bi.count);
        else passed++;
        bi.wb_valid = 1'b1; bi.wb_rd = 5'd10; tick(); bi.wb_valid = 1'b0;
        tick();
        total++;
        if (dut_iss.size() != 5 || dut_iss[0] !== p || dut_iss[1] !== f || dut_iss[2] !== a ||
            dut_iss[3] !== d || dut_iss[4] !== e)
            $display("FAIL hz_order: issued=%0d want P,F,A,D,E", dut_iss.size());
        else passed++;
    endtask

    task automatic test_fill();
        logic [31:0] x;
        bit          ok;
        x = mk(20, 0, 0);
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            drv(mk(i + 1, 0, 0)); tick();
        end
        total++;
        if (bi.in_ready !== 1'b0 || bi.count !== 5'd16)
            $display("FAIL fill_full: ready=%0b count=%0d want 0/16", bi.in_ready, bi.count);
        else passed++;
        drv(x); tick();
        total++;
        if (bi.count !== 5'd16) $display("FAIL fill_no_overflow: count=%0d want 16", bi.count);
        else passed++;
        bi.out_ready = 1'b1; tick();
        total++;
        if (bi.count !== 5'd15 || bi.in_ready !== 1'b1)
            $display("FAIL fill_slot_freed: count=%0d ready=%0b want 15/1", bi.count, bi.in_ready);
        else passed++;
        tick();
        bi.in_valid = 1'b0;
        total++;
        if (bi.count !== 5'd15) $display("FAIL fill_accept_issue: count=%0d want 15", bi.count);
        else passed++;
        for (int c = 0; c < 40 && bi.count != 0; c++) tick();
        ok = (bi.count == 0) && (dut_iss.size() == DEPTH + 1) && (dut_iss[DEPTH] === x);
        for (int i = 0; i < DEPTH && ok; i++) if (dut_iss[i] !== mk(i + 1, 0, 0)) ok = 1'b0;
        total++;
        if (!ok) $display("FAIL fill_drain_order: count=%0d issued=%0d want 0/%0d, new instr last",
                          bi.count, dut_iss.size(), DEPTH + 1);
        else passed++;
    endtask

    task automatic test_stability();
        logic [31:0] s;
        bit          ok;
        s = mk(3, 0, 0);
        do_reset();
        drv(s); tick();
        for (int c = 0; c < 5; c++) begin
            drv(mk(11 + c, 0, 0)); tick();
            total++;
            if (bi.out_valid !== 1'b1 || bi.out_instr !== s)
                $display("FAIL stable_hold_%0d: valid=%0b instr=%h want 1/%h", c, bi.out_valid, bi.out_instr, s);
            else passed++;
        end
        bi.in_valid = 1'b0;
        bi.out_ready = 1'b1;
        for (int c = 0; c < 20 && bi.count != 0; c++) tick();
        ok = (bi.count == 0) && (dut_iss.size() == 6) && (dut_iss[0] === s);
        for (int i = 1; i < 6 && ok; i++) if (dut_iss[i] !== mk(10 + i, 0, 0)) ok = 1'b0;
        total++;
        if (!ok) $display("FAIL stable_drain: count=%0d issued=%0d want 0/6 in push order",
                          bi.count, dut_iss.size());
        else passed++;
    endtask

    task automatic test_random();
        int          k;
        logic [31:0] exp_instr;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            bi.in_valid    = ($urandom % 4) != 0;
            bi.in_instr    = mk($urandom % 8, $urandom % 8, $urandom % 8);
            bi.in_regwrite = ($urandom % 4) != 0;
            bi.in_alusrc   = ($urandom % 10) < 3;
            bi.out_ready   = ($urandom % 3) != 0;
            bi.wb_valid    = ($urandom % 3) == 0;
            bi.wb_rd       = 5'($urandom % 8);
            rst            = (c == 300);
            k         = m_pick();
            exp_instr = (k >= 0) ? mq[k].instr : 32'd0;
            total++;
            if (bi.out_valid !== (k >= 0) || bi.out_instr !== exp_instr ||
                bi.count !== 5'(mq.size()) || bi.in_ready !== (mq.size() < DEPTH))
                $display("FAIL rand_cycle_%0d: valid=%0b instr=%h count=%0d ready=%0b want %0b/%h/%0d/%0b",
                         c, bi.out_valid, bi.out_instr, bi.count, bi.in_ready,
                         (k >= 0), exp_instr, mq.size(), (mq.size() < DEPTH));
            else passed++;
            tick();
        end
        rst = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: sim time %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        total  = 0;
        passed = 0;
        rst    = 1'b1;
        test_reset();
        test_out_of_order();
        test_in_order();
        test_war_waw();
        test_fill();
        test_stability();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
